// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared encodings for the fetch controller and the program counter it drives.
package pc_fetch_ctrl_pkg;

    localparam int PC_W  = 16;
    localparam int TMO_W = 8;

    typedef enum logic [1:0] {
        PC_OP_RESET  = 2'd0,
        PC_OP_PRESET = 2'd1,
        PC_OP_INCR   = 2'd2,
        PC_OP_HALT   = 2'd3
    } pc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_FETCH  = 3'd3,
        ST_HALTED = 3'd4,
        ST_ERROR  = 3'd5
    } fetch_state_e;

    function automatic logic is_busy_state(input fetch_state_e s);
        return (s == ST_LOAD) || (s == ST_SETTLE) || (s == ST_FETCH);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request channel plus the program counter control/feedback pair.
interface pc_fetch_ctrl_if;
    import pc_fetch_ctrl_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    pc_op_e          pc_opcode;
    logic [PC_W-1:0] pc_in;
    logic [PC_W-1:0] pc_fb;

    modport master (
        output imem_req, imem_addr, pc_opcode, pc_in,
        input  imem_ack, pc_fb
    );

    modport slave (
        input  imem_req, imem_addr, pc_opcode, pc_in,
        output imem_ack, pc_fb
    );

endinterface

// File: rtl/pc_fetch_ctrl_ack_timeout_counter.sv
// Counts FETCH cycles spent without an ack; terminal flags the cycle that reaches LIMIT.
module pc_fetch_ctrl_ack_timeout_counter
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int LIMIT = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TMO_W'(1);
        end
    end

    // Flag one count early so the FSM leaves FETCH on the edge the limit is hit.
    assign terminal = (count == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Sequences instruction fetches: drives the program counter opcode and the imem request.
// IDLE: pc reset | LOAD: preset RESET_VECTOR | SETTLE: let pc_fb settle | FETCH: request out | HALTED / ERROR: pc held
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000,
    parameter int              ACK_TIMEOUT  = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              halt_req,
    input  logic              resume,
    pc_fetch_ctrl_if.master   bus,
    output logic              fetch_valid,
    output logic [PC_W-1:0]   fetch_pc,
    output logic              busy,
    output logic              error
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    pc_op_e          pc_op;
    logic [PC_W-1:0] pc_in_c;
    logic            fire;
    logic            start_accept;
    logic            br_pend;
    logic [PC_W-1:0] br_target_q;
    logic            tmo_enable;
    logic            tmo_clear;
    logic            tmo_terminal;
    logic            imem_req_q;
    logic [PC_W-1:0] imem_addr_q;

    assign tmo_enable   = (state == ST_FETCH) && !bus.imem_ack;
    assign tmo_clear    = !tmo_enable;
    assign start_accept = (state_nxt == ST_LOAD);

    pc_fetch_ctrl_ack_timeout_counter #(
        .LIMIT (ACK_TIMEOUT)
    ) u_ack_timeout_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (tmo_clear),
        .enable   (tmo_enable),
        .terminal (tmo_terminal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_op     = PC_OP_PRESET;
        pc_in_c   = bus.pc_fb;
        fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                pc_op   = PC_OP_RESET;
                pc_in_c = '0;
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                pc_in_c   = RESET_VECTOR;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (halt_req)    state_nxt = ST_HALTED;
                else if (!stall) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    fire      = 1'b1;
                    state_nxt = ST_SETTLE;
                    // A same-cycle branch beats an older latched one.
                    if (branch_valid)  pc_in_c = branch_target;
                    else if (br_pend)  pc_in_c = br_target_q;
                    else               pc_op   = PC_OP_INCR;
                end else if (tmo_terminal) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_HALTED: begin
                if (start)                    state_nxt = ST_LOAD;
                else if (resume && !halt_req) state_nxt = ST_SETTLE;
            end
            ST_ERROR: begin
                if (start) state_nxt = ST_LOAD;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.pc_opcode = pc_op;
    assign bus.pc_in     = pc_in_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            br_pend     <= 1'b0;
            br_target_q <= '0;
        end else if (start_accept || fire) begin
            br_pend     <= 1'b0;
        end else if (branch_valid) begin
            br_pend     <= 1'b1;
            br_target_q <= branch_target;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            imem_req_q  <= (state_nxt == ST_FETCH);
            if (state_nxt == ST_FETCH) imem_addr_q <= bus.pc_fb;
            fetch_valid <= fire;
            if (fire) fetch_pc <= bus.pc_fb;
            busy        <= is_busy_state(state_nxt);
            error       <= (state_nxt == ST_ERROR);
        end
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Fetch controller bench: PC register and imem responder around the DUT, transaction-level expectations.
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    localparam logic [15:0] RV  = 16'h0100;
    localparam int          TMO = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = '0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic        busy;
    logic        error;
    logic [15:0] pc_reg = '0;

    pc_fetch_ctrl_if bus();

    pc_fetch_ctrl #(
        .RESET_VECTOR (RV),
        .ACK_TIMEOUT  (TMO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .bus           (bus),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .busy          (busy),
        .error         (error)
    );

    always #5 clock = ~clock;

    // Neighbouring program counter register.
    always @(posedge clock) begin
        case (bus.pc_opcode)
            PC_OP_RESET:  pc_reg <= '0;
            PC_OP_PRESET: pc_reg <= bus.pc_in;
            PC_OP_INCR:   pc_reg <= pc_reg + 16'd1;
            default:      pc_reg <= pc_reg;
        endcase
    end
    assign bus.pc_fb = pc_reg;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_pc = '0;
    logic [15:0] last_addr = '0;
    logic [15:0] pend_tgt = '0;
    bit          pend = 0;
    bit          acked_last = 0;
    bit          timeout_due = 0;
    bit          req_unacked = 0;
    bit          model_err = 0;
    bit          model_idle = 1;
    int          wait_cnt = 0;
    int          gap = 0;
    int          ack_delay = 1;
    bit          ack_rand_mode = 0;
    bit          br_req = 0;
    logic [15:0] br_tgt = '0;
    int          n_fetch = 0;
    logic [15:0] seen[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Drive inputs for the coming edge, update expectations, then inspect at the next falling edge.
    task automatic cycle();
        bit acked;
        acked = 0;
        if (bus.imem_req) begin
            if (ack_rand_mode) acked = ($urandom_range(2) != 0);
            else               acked = (ack_delay >= 0) && (wait_cnt >= ack_delay);
        end
        bus.imem_ack  = acked;
        branch_valid  = br_req;
        branch_target = br_tgt;
        br_req        = 0;
        acked_last    = acked;
        req_unacked   = 0;
        if (acked) begin
            last_addr = exp_pc;
            exp_pc    = branch_valid ? branch_target : (pend ? pend_tgt : exp_pc + 16'd1);
            pend      = 0;
            wait_cnt  = 0;
        end else begin
            if (branch_valid) begin
                pend     = 1;
                pend_tgt = branch_target;
            end
            if (bus.imem_req) begin
                wait_cnt++;
                if (wait_cnt == TMO) begin
                    timeout_due = 1;
                    wait_cnt    = 0;
                end else begin
                    req_unacked = 1;
                end
            end
        end
        if (start && reset_n && (model_err || model_idle)) begin
            model_err  = 0;
            model_idle = 0;
            exp_pc     = RV;
            pend       = 0;
        end

        @(negedge clock);
        chk("op_legal", 32'(bus.pc_opcode == PC_OP_HALT), 32'd0);
        chk("fetch_valid", 32'(fetch_valid), 32'(acked_last));
        if (fetch_valid) seen.push_back(fetch_pc);
        if (acked_last) begin
            chk("fetch_pc", 32'(fetch_pc), 32'(last_addr));
            chk("pc_after_fetch", 32'(bus.pc_fb), 32'(exp_pc));
            n_fetch++;
        end
        if (timeout_due) begin
            chk("tmo_req_drop", 32'(bus.imem_req), 32'd0);
            chk("tmo_pc_held", 32'(bus.pc_fb), 32'(exp_pc));
            model_err   = 1;
            timeout_due = 0;
        end else if (req_unacked) begin
            chk("req_hold", 32'(bus.imem_req), 32'd1);
        end
        chk("error", 32'(error), 32'(model_err));
        if (model_err || model_idle) begin
            chk("inactive_busy", 32'(busy), 32'd0);
            chk("inactive_req", 32'(bus.imem_req), 32'd0);
        end
        if (bus.imem_req) chk("imem_addr", 32'(bus.imem_addr), 32'(exp_pc));
        if (bus.imem_req || model_err || model_idle || stall || halt_req || !reset_n) gap = 0;
        else gap++;
        if (gap > 4) begin
            chk("fetch_progress", 32'(gap), 32'd0);
            gap = 0;
        end
    endtask

    task automatic run_fetches(input int n);
        int guard;
        guard = 0;
        while (seen.size() < n && guard < 40 * n) begin
            cycle();
            guard++;
        end
        chk("fetch_count", 32'(seen.size()), 32'(n));
    endtask

    task automatic wait_req(input bit any_addr, input logic [15:0] addr);
        int guard;
        guard = 0;
        while (!(bus.imem_req && wait_cnt == 0 && (any_addr || bus.imem_addr == addr)) && guard < 200) begin
            cycle();
            guard++;
        end
        chk("reach_req", 32'(guard < 200), 32'd1);
    endtask

    task automatic check_seen(input string tag, input int idx, input logic [15:0] expv);
        logic [15:0] got;
        got = (idx < seen.size()) ? seen[idx] : 16'hxxxx;
        chk(tag, 32'(got), 32'(expv));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int req_cycles;
        int guard;
        int rand_start;
        bus.imem_ack = 1'b0;

        // Reset values
        repeat (2) @(negedge clock);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_fvalid", 32'(fetch_valid), 32'd0);
        chk("rst_fpc", 32'(fetch_pc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_opcode", 32'(bus.pc_opcode), 32'd0);
        reset_n = 1'b1;
        cycle();
        chk("idle_opcode", 32'(bus.pc_opcode), 32'd0);
        chk("idle_pc_in", 32'(bus.pc_in), 32'd0);

        // Start from the reset vector, acks after one wait cycle
        ack_delay = 1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("load_opcode", 32'(bus.pc_opcode), 32'd1);
        chk("load_pc_in", 32'(bus.pc_in), 32'(RV));
        seen.delete();
        run_fetches(3);
        check_seen("seq_0", 0, 16'h0100);
        check_seen("seq_1", 1, 16'h0101);
        check_seen("seq_2", 2, 16'h0102);

        // Branch latched while waiting for the ack at 0105
        ack_delay = 2;
        wait_req(0, 16'h0105);
        seen.delete();
        br_req = 1; br_tgt = 16'h2000;
        run_fetches(3);
        check_seen("br_0", 0, 16'h0105);
        check_seen("br_1", 1, 16'h2000);
        check_seen("br_2", 2, 16'h2001);

        // Wrap from FFFF
        ack_delay = 1;
        wait_req(1, 16'h0000);
        br_req = 1; br_tgt = 16'hFFFF;
        seen.delete();
        run_fetches(3);
        check_seen("wrap_ffff", 1, 16'hFFFF);
        check_seen("wrap_0000", 2, 16'h0000);
        chk("wrap_error", 32'(error), 32'd0);

        // Ack timeout and restart
        guard = 0;
        while (bus.imem_req && guard < 20) begin cycle(); guard++; end
        ack_delay = -1;
        req_cycles = 0;
        guard = 0;
        while (!error && guard < 30) begin
            cycle();
            if (bus.imem_req) req_cycles++;
            guard++;
        end
        chk("tmo_req_cycles", 32'(req_cycles), 32'(TMO));
        chk("tmo_error_set", 32'(error), 32'd1);
        ack_delay = 1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        seen.delete();
        run_fetches(1);
        check_seen("restart_pc", 0, RV);
        chk("restart_error", 32'(error), 32'd0);

        // Halt requested during the fetch at 0010
        wait_req(1, 16'h0000);
        br_req = 1; br_tgt = 16'h0010;
        wait_req(0, 16'h0010);
        halt_req = 1'b1;
        seen.delete();
        run_fetches(1);
        check_seen("halt_fetch", 0, 16'h0010);
        cycle();
        for (int i = 0; i < 20; i++) begin
            cycle();
            chk("halt_pc", 32'(bus.pc_fb), 32'h0011);
            chk("halt_req_low", 32'(bus.imem_req), 32'd0);
            chk("halt_busy", 32'(busy), 32'd0);
        end
        halt_req = 1'b0;
        resume = 1'b1;
        cycle();
        resume = 1'b0;
        seen.delete();
        run_fetches(1);
        check_seen("resume_pc", 0, 16'h0011);

        // Reset while a request is outstanding
        ack_delay = 3;
        wait_req(1, 16'h0000);
        cycle();
        #2 reset_n = 1'b0;
        bus.imem_ack = 1'b0;
        #1;
        chk("arst_req", 32'(bus.imem_req), 32'd0);
        chk("arst_addr", 32'(bus.imem_addr), 32'd0);
        chk("arst_fvalid", 32'(fetch_valid), 32'd0);
        chk("arst_fpc", 32'(fetch_pc), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_opcode", 32'(bus.pc_opcode), 32'd0);
        model_idle = 1; model_err = 0; pend = 0; wait_cnt = 0;
        repeat (3) cycle();
        reset_n = 1'b1;
        ack_delay = 1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        seen.delete();
        run_fetches(2);
        check_seen("post_rst_0", 0, RV);
        check_seen("post_rst_1", 1, RV + 16'd1);

        // Randomized traffic: stalls, branches, ragged acks, occasional timeouts
        ack_rand_mode = 1;
        rand_start = n_fetch;
        for (int i = 0; i < 800; i++) begin
            stall = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0) begin
                br_req = 1;
                br_tgt = 16'($urandom);
            end
            start = model_err;
            cycle();
        end
        start = 1'b0;
        stall = 1'b0;
        chk("rand_progress", 32'(n_fetch - rand_start > 50), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
